// File: rtl/ranger_pkg.sv
// ranger_pkg: definitions shared between the ultrasonic ranger and the
// sequencer that drives it.
//   ranger_state_t : FSM state encoding of echo_ranger
//   US_PER_CM      : microseconds of echo round trip per centimetre
//   DIST_NO_ECHO   : distance code reported when no echo ever rose
package ranger_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        DONE
    } ranger_state_t;

    localparam int unsigned US_PER_CM    = 58;
    localparam logic [8:0]  DIST_NO_ECHO = 9'd511;

endpackage

// File: rtl/us_tick.sv
// us_tick: one-cycle tick every CYC_PER_US clocks (one microsecond).
//   clk     : clock
//   rst     : synchronous active-high reset
//   restart : zeroes the phase counter so the first tick lands a full
//             microsecond after the restart cycle
//   tick    : high for one cycle at the end of each microsecond
module us_tick #(
    parameter int unsigned CYC_PER_US = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CW'(CYC_PER_US - 1));

endmodule

// File: rtl/echo_ranger.sv
// echo_ranger: ultrasonic range finder controller. Issues a stretched
// trigger pulse, waits for the echo, times its high phase in microseconds
// and converts it to centimetres (truncated), saturating at MAX_CM.
//   clk, rst    : clock, synchronous active-high reset
//   clear       : abort any measurement, result registers are kept
//   trigger     : one-cycle start request, honoured only in IDLE
//   echo        : raw sensor echo, asynchronous
//   trig_out    : trigger pulse to the sensor
//   distance_cm : last result (511 = no echo)
//   valid       : one-cycle strobe when distance_cm updates
//   timeout     : last measurement had no echo or saturated
//   busy        : FSM not in IDLE
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | waiting for trigger
// TRIG      | driving trig_out for TRIG_US
// WAIT_ECHO | waiting up to WAIT_US for a synchronized echo rise
// MEASURE   | counting echo high time into cm
// DONE      | result loaded, valid strobe, back to IDLE
module echo_ranger
    import ranger_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TRIG_US = 10,
    parameter int unsigned WAIT_US = 30_000,
    parameter int unsigned MAX_CM  = 400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       trigger,
    input  logic       echo,
    output logic       trig_out,
    output logic [8:0] distance_cm,
    output logic       valid,
    output logic       timeout,
    output logic       busy
);

    localparam int unsigned CYC_PER_US = CLK_HZ / 1_000_000;
    localparam int unsigned US_MAX     = (WAIT_US > TRIG_US) ? WAIT_US : TRIG_US;
    localparam int unsigned US_W       = $clog2(US_MAX + 1);

    ranger_state_t state, state_next;

    logic            echo_s1, echo_s2, echo_d;
    logic            tick, restart;
    logic [US_W-1:0] us_left;
    logic [5:0]      sub_cnt;
    logic [8:0]      cm_cnt;

    logic echo_rise, echo_fall, us_done, cm_step, cm_sat;

    assign echo_rise = echo_s2 & ~echo_d;
    assign echo_fall = ~echo_s2 & echo_d;
    assign us_done   = tick && (us_left == '0);
    assign cm_step   = tick && (sub_cnt == 6'(US_PER_CM - 1));
    assign cm_sat    = cm_step && (cm_cnt == 9'(MAX_CM - 1));

    // Phase restarts on every state change so each interval is measured
    // from the cycle the state was entered.
    assign restart = (state_next != state) || clear;

    us_tick #(
        .CYC_PER_US(CYC_PER_US)
    ) u_us_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:      if (trigger) state_next = TRIG;
                TRIG:      if (us_done) state_next = WAIT_ECHO;
                WAIT_ECHO: begin
                    if (echo_rise)    state_next = MEASURE;
                    else if (us_done) state_next = DONE;
                end
                MEASURE:   if (cm_sat || echo_fall) state_next = DONE;
                DONE:      state_next = IDLE;
                default:   state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            echo_s1     <= 1'b0;
            echo_s2     <= 1'b0;
            echo_d      <= 1'b0;
            us_left     <= '0;
            sub_cnt     <= '0;
            cm_cnt      <= '0;
            distance_cm <= '0;
            timeout     <= 1'b0;
        end else begin
            echo_s1 <= echo;
            echo_s2 <= echo_s1;
            echo_d  <= echo_s2;

            if (clear) begin
                us_left <= '0;
                sub_cnt <= '0;
                cm_cnt  <= '0;
            end else begin
                if (state_next == TRIG && state != TRIG) begin
                    us_left <= US_W'(TRIG_US - 1);
                end else if (state_next == WAIT_ECHO && state != WAIT_ECHO) begin
                    us_left <= US_W'(WAIT_US - 1);
                end else if (tick && us_left != '0) begin
                    us_left <= us_left - 1'b1;
                end

                if (state_next == MEASURE && state != MEASURE) begin
                    sub_cnt <= '0;
                    cm_cnt  <= '0;
                end else if (state == MEASURE && tick) begin
                    if (cm_step) begin
                        sub_cnt <= '0;
                        cm_cnt  <= cm_cnt + 1'b1;
                    end else begin
                        sub_cnt <= sub_cnt + 1'b1;
                    end
                end

                // The microsecond ending in the fall cycle still counts,
                // so the result covers the full synchronized high time.
                if (state_next == DONE) begin
                    if (state == WAIT_ECHO) begin
                        distance_cm <= DIST_NO_ECHO;
                        timeout     <= 1'b1;
                    end else if (cm_sat) begin
                        distance_cm <= 9'(MAX_CM);
                        timeout     <= 1'b1;
                    end else begin
                        distance_cm <= cm_cnt + 9'(cm_step);
                        timeout     <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        trig_out = (state == TRIG);
        valid    = (state == DONE);
        busy     = (state != IDLE);
    end

endmodule

// File: tb/tb_echo_ranger.sv
// tb_echo_ranger: table-driven and randomized checks of echo_ranger at a
// 2 MHz clock. Echo windows are given in cycles counted from the first
// cycle after the trigger request; WAIT_ECHO is entered at cycle 20.
// WAIT_US is shortened so the whole run stays small.
module tb_echo_ranger;

    localparam int CLK_HZ  = 2_000_000;
    localparam int TRIG_US = 10;
    localparam int WAIT_US = 2_000;
    localparam int MAX_CM  = 400;
    localparam int CYC     = CLK_HZ / 1_000_000;
    localparam int CM_US   = 58;
    localparam int LIMIT   = 60_000;

    logic       clk = 1'b0;
    logic       rst, clear, trigger, echo;
    logic       trig_out, valid, timeout, busy;
    logic [8:0] distance_cm;

    int checks = 0;
    int errors = 0;

    echo_ranger #(
        .CLK_HZ (CLK_HZ),
        .TRIG_US(TRIG_US),
        .WAIT_US(WAIT_US),
        .MAX_CM (MAX_CM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .trigger    (trigger),
        .echo       (echo),
        .trig_out   (trig_out),
        .distance_cm(distance_cm),
        .valid      (valid),
        .timeout    (timeout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    e1_s, e1_w, e2_s, e2_w;
        int    clr_at, trg_at;
        int    exp_trig, exp_valid, exp_vcyc, exp_dist, exp_to;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: distance is whole microseconds of echo high time divided
    // by 58, capped at MAX_CM; result appears 3 cycles after the raw echo
    // falls (2-flop sync + edge). No echo times out WAIT_US after WAIT entry.
    function automatic vec_t model(input string nm, input int es, input int wid);
        vec_t v;
        int   us;
        v.name = nm; v.e1_s = es; v.e1_w = wid; v.e2_s = 0; v.e2_w = 0;
        v.clr_at = -1; v.trg_at = -1;
        v.exp_trig = TRIG_US * CYC; v.exp_valid = 1;
        us = wid / CYC;
        if (wid == 0) begin
            v.exp_dist = 511; v.exp_to = 1; v.exp_vcyc = TRIG_US * CYC + WAIT_US * CYC;
        end else if (us / CM_US >= MAX_CM) begin
            v.exp_dist = MAX_CM; v.exp_to = 1; v.exp_vcyc = es + 3 + CM_US * MAX_CM * CYC;
        end else begin
            v.exp_dist = us / CM_US; v.exp_to = 0; v.exp_vcyc = es + wid + 3;
        end
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int       trig_len = 0;
        int       n_valid = 0;
        int       vcyc = -1;
        int       vdist = 0;
        int       vto = 0;
        int       busy0 = 0;
        int       busy_clr = 1;
        int       min_len;
        bit       expired = 1'b0;
        min_len = v.e1_s + v.e1_w;
        if (v.e2_s + v.e2_w > min_len) min_len = v.e2_s + v.e2_w;
        min_len = min_len + 5;
        if (min_len < 22) min_len = 22;

        @(negedge clk);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        for (int cyc = 0; ; cyc++) begin
            if (cyc == 0) busy0 = int'(busy);
            if (trig_out) trig_len++;
            if (valid) begin
                n_valid++;
                vcyc  = cyc;
                vdist = int'(distance_cm);
                vto   = int'(timeout);
            end
            if (v.clr_at >= 0 && cyc == v.clr_at + 1) busy_clr = int'(busy);
            if (cyc >= min_len && !busy) break;
            if (cyc >= LIMIT) begin
                expired = 1'b1;
                break;
            end
            echo = ((cyc >= v.e1_s) && (cyc < v.e1_s + v.e1_w)) ||
                   ((cyc >= v.e2_s) && (cyc < v.e2_s + v.e2_w));
            clear   = (cyc == v.clr_at);
            trigger = (cyc == v.trg_at);
            @(negedge clk);
        end
        echo = 1'b0; clear = 1'b0; trigger = 1'b0;

        check({v.name, ".finished"}, int'(expired), 0);
        check({v.name, ".busy_in_trig"}, busy0, 1);
        check({v.name, ".trig_len"}, trig_len, v.exp_trig);
        check({v.name, ".n_valid"}, n_valid, v.exp_valid);
        if (v.exp_valid != 0) begin
            check({v.name, ".valid_cycle"}, vcyc, v.exp_vcyc);
            check({v.name, ".dist_at_valid"}, vdist, v.exp_dist);
            check({v.name, ".timeout_at_valid"}, vto, v.exp_to);
        end
        if (v.clr_at >= 0) check({v.name, ".busy_after_clear"}, busy_clr, 0);
        check({v.name, ".dist_final"}, int'(distance_cm), v.exp_dist);
        check({v.name, ".timeout_final"}, int'(timeout), v.exp_to);
    endtask

    initial begin
        #(200_000 * 10);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; trigger = 1'b0; echo = 1'b0;

        //          name          e1_s e1_w   e2_s e2_w  clr  trg  trig val vcyc   dist to
        vecs.push_back('{"echo580",    40, 1160,    0,   0,  -1,  -1, 20, 1,  1203,   10, 0});
        vecs.push_back('{"no_echo",     0,    0,    0,   0,  -1,  -1, 20, 1,  4020,  511, 1});
        vecs.push_back('{"pre_high",    5,   60,  100, 1160, -1,  -1, 20, 1,  1263,   10, 0});
        vecs.push_back('{"trig_mid",   40, 1160,    0,   0,  -1, 600, 20, 1,  1203,   10, 0});
        vecs.push_back('{"us57",       30,  115,    0,   0,  -1,  -1, 20, 1,   148,    0, 0});
        vecs.push_back('{"us58",       30,  116,    0,   0,  -1,  -1, 20, 1,   149,    1, 0});
        vecs.push_back('{"clear300",   40, 1160,    0,   0, 643,  -1, 20, 0,    -1,    1, 0});
        vecs.push_back('{"clear_trig",  0,    0,    0,   0,   8,  -1,  9, 0,    -1,    1, 0});
        vecs.push_back('{"saturate",   40, 50000,   0,   0,  -1,  -1, 20, 1, 46443,  400, 1});
        vecs.push_back('{"clear_wait",  0,    0,    0,   0, 200,  -1, 20, 0,    -1,  400, 1});

        repeat (3) @(negedge clk);
        check("rst.busy", int'(busy), 0);
        check("rst.trig_out", int'(trig_out), 0);
        check("rst.valid", int'(valid), 0);
        check("rst.distance", int'(distance_cm), 0);
        check("rst.timeout", int'(timeout), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        for (int n = 0; n < 6; n++) begin
            int es, wid;
            es  = int'($urandom_range(25, 500));
            wid = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(2, 1900));
            run_vec(model($sformatf("rand%0d", n), es, wid));
        end

        // reset mid-measurement wins over trigger and discards the result
        @(negedge clk); trigger = 1'b1;
        @(negedge clk); trigger = 1'b0;
        repeat (40) @(negedge clk);
        echo = 1'b1;
        repeat (300) @(negedge clk);
        check("rst_mid.busy_before", int'(busy), 1);
        rst = 1'b1; trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        check("rst_mid.busy", int'(busy), 0);
        check("rst_mid.distance", int'(distance_cm), 0);
        check("rst_mid.timeout", int'(timeout), 0);
        check("rst_mid.valid", int'(valid), 0);
        rst = 1'b0; echo = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid.idle_after", int'(busy), 0);

        // clear beats a simultaneous trigger
        clear = 1'b1; trigger = 1'b1;
        @(negedge clk);
        clear = 1'b0; trigger = 1'b0;
        check("clr_trg.busy", int'(busy), 0);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        check("trg_alone.busy", int'(busy), 1);
        check("trg_alone.trig_out", int'(trig_out), 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_abort.busy", int'(busy), 0);
        check("clr_abort.trig_out", int'(trig_out), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
